adc_readout_seq: RTL
====================

Name: adc_readout_seq

Overview:
- Bus initiator for the ADC frontend control interface. Enables ADC readout, then walks the enabled channel addresses (0..31; addr[4:2] = ADC, addr[1:0] = lane a/b/c/d).
- Issues one read per channel and checks the returned valid marker.
- Emits each sample on a ready/valid stream toward the event builder.
- Sits between the frontend's control slave port and the packet/USB path.

Parameters:
- N_ADDR, 32, number of channel addresses scanned (0..N_ADDR-1); max 32.
- TIMEOUT_CYCLES, 1024, read-wait cycle limit (used only with the optional feature).

Ports:
- clk  in  1  system clock, 133 MHz
- reset  in  1  synchronous, active-high
- start  in  1  single-cycle pulse; begin a run
- stop  in  1  single-cycle pulse; end the run at the next channel boundary
- chan_mask  in  32  enabled channel addresses; sampled on accepted start
- running  out  1  high from accepted start until disable write completes
- write_req  out  1  control bus write strobe
- read_req  out  1  control bus read strobe
- data_write  out  32  control bus write data
- addr  out  26  control bus address
- busy  in  1  slave busy (combinationally includes write_req/read_req)
- data_read  in  32  slave read data; valid in first cycle busy is low after a read
- out_valid  out  1  stream valid
- out_ready  in  1  stream ready
- out_data  out  16  [15] first-of-frame, [14:10] channel address, [9:0] sample
- frame_count  out  16  completed full scans; wraps 0xFFFF->0
- marker_err  out  1  sticky; data_read[31:10] != 22'd1 seen
- timeout_err  out  1  sticky; see Optional Feature

Behaviour:
- Reset values: all outputs 0; state IDLE; stop_pending 0.
- Bus rules:
  - A strobe is asserted only when busy==0 in the same cycle.
  - Every strobe lasts exactly one cycle.
  - read_req and write_req are never asserted together.
  - addr and data_write are driven during the strobe cycle only; 0 otherwise.
- FSM states and transitions:
  - IDLE: on start with chan_mask!=0, latch mask, set running, go EN_WR. start with mask==0 is ignored.
  - EN_WR: when busy==0, write_req=1, addr=0, data_write=1; go SCAN, ch = lowest set mask bit, first=1.
  - SCAN: if stop_pending, go DIS_WR; else go RD_REQ.
  - RD_REQ: when busy==0, read_req=1, addr={21'd0,ch}; go RD_WAIT.
  - RD_WAIT: stay while busy==1. When busy==0:
    - capture data_read[9:0]; set marker_err if [31:10] != 22'd1 (sample still forwarded);
    - load out_data={first,ch,sample}, out_valid=1; go PUSH.
  - PUSH: hold out_valid and out_data stable until out_ready. On handshake:
    - first=0; ch = next set mask bit above ch;
    - if none, ch = lowest set bit, first=1, frame_count+1;
    - go SCAN.
  - DIS_WR: when busy==0, write_req=1, addr=0, data_write=0; clear running, stop_pending; go IDLE.
- Stop and start handling:
  - stop in any non-IDLE state sets stop_pending. The in-flight read always completes and its sample is pushed (no dropped/partial reads).
  - stop in IDLE is ignored. start while running is ignored.
  - start and stop in the same IDLE cycle: start wins; stop is ignored.
- Timing and latency:
  - Minimum cycles per sample = 1 (RD_REQ) + slave latency + 1 (PUSH with out_ready=1) + 1 (SCAN).
  - No skid buffer: backpressure stalls the scan.
- Mask bits >= N_ADDR are ignored. A mask with a single bit re-reads that channel; every sample then has first=1.
- Mid-operation reset: return to IDLE immediately, outputs to reset values, no disable write issued (the slave resets with the same signal).

Optional Feature:
- Macro ADC_SEQ_TIMEOUT_EN.
- Defined:
  - a 16-bit counter runs in RD_WAIT;
  - on reaching TIMEOUT_CYCLES with busy still high, set timeout_err (sticky);
  - the FSM keeps waiting, since the slave cannot abort a read.
- Undefined: no counter; timeout_err tied 0.

Decomposition:
- Package adc_seq_pkg:
  - FSM state encoding;
  - ADDR_ENABLE = 26'd0, VALID_MARKER = 22'd1;
  - out_data field offsets (FIRST_BIT=15, CH_LSB=10, SAMPLE_W=10).
- Sub-module adc_chan_pick: combinational next-set-bit finder.
  - Inputs: mask, current ch.
  - Outputs: next ch, wrapped flag, lowest ch.

Test Plan:
- start, mask=0x0000_0005, slave model with 2-cycle latency returning {22'd1,10'h155}/{22'd1,10'h0AA}, out_ready=1 -> write 1 @addr0; reads addr 0 then 2; out_data 0x8155 then 0x08AA; repeats; frame_count increments once per pair.
- out_ready low 20 cycles during PUSH -> out_valid/out_data stable; no read_req issued until handshake.
- stop while in RD_WAIT on ch 2 -> that sample is pushed; next bus op is write addr0 data 0; running falls; no further reads.
- Slave returns 0x0000_0000 for one read -> marker_err=1 and stays set; sample 0x000 forwarded.
- Slave busy held high 2000 cycles with ADC_SEQ_TIMEOUT_EN defined -> timeout_err=1 at cycle 1024 of RD_WAIT; completes normally when busy drops. Macro undefined -> timeout_err stays 0.
- Reset asserted in RD_WAIT, start=1 with mask=0, start during run -> all outputs 0 after reset; zero-mask start ignored; duplicate start has no effect.

Source files
------------

// File: rtl/adc_seq_pkg.sv
// Shared types and constants for the ADC readout sequencer: FSM states,
// control-bus constants and the layout of the outgoing sample word.
package adc_seq_pkg;

  localparam int ADDR_W    = 26;
  localparam int BUS_W     = 32;
  localparam int OUT_W     = 16;
  localparam int CH_W      = 5;
  localparam int FIRST_BIT = 15;
  localparam int CH_LSB    = 10;
  localparam int SAMPLE_W  = 10;
  localparam int MARKER_W  = BUS_W - SAMPLE_W;

  localparam logic [ADDR_W-1:0]   ADDR_ENABLE  = 26'd0;
  localparam logic [MARKER_W-1:0] VALID_MARKER = 22'd1;

  typedef enum logic [2:0] {
    IDLE,
    EN_WR,
    SCAN,
    RD_REQ,
    RD_WAIT,
    PUSH,
    DIS_WR
  } state_t;

  function automatic logic [OUT_W-1:0] pack_sample(
    input logic                first,
    input logic [CH_W-1:0]     ch,
    input logic [SAMPLE_W-1:0] sample
  );
    logic [OUT_W-1:0] w;
    w = '0;
    w[FIRST_BIT]       = first;
    w[CH_LSB +: CH_W]  = ch;
    w[SAMPLE_W-1:0]    = sample;
    return w;
  endfunction

endpackage

// File: rtl/adc_readout_seq_if.sv
// Control-bus and sample-stream signals between the readout sequencer
// (master) and the frontend slave / event builder (slave).
interface adc_readout_seq_if;
  import adc_seq_pkg::*;

  logic              write_req;
  logic              read_req;
  logic [BUS_W-1:0]  data_write;
  logic [ADDR_W-1:0] addr;
  logic              busy;
  logic [BUS_W-1:0]  data_read;

  logic              out_valid;
  logic              out_ready;
  logic [OUT_W-1:0]  out_data;

  modport master (
    output write_req, read_req, data_write, addr, out_valid, out_data,
    input  busy, data_read, out_ready
  );

  modport slave (
    input  write_req, read_req, data_write, addr, out_valid, out_data,
    output busy, data_read, out_ready
  );
endinterface

// File: rtl/adc_chan_pick.sv
// Combinational channel picker: next enabled channel above ch (wrapping to
// the lowest enabled one) plus the lowest enabled channel on its own.
module adc_chan_pick
  import adc_seq_pkg::*;
(
  input  logic [31:0]     mask,
  input  logic [CH_W-1:0] ch,
  output logic [CH_W-1:0] next_ch,
  output logic            wrapped,
  output logic [CH_W-1:0] lowest_ch
);

  logic [CH_W-1:0] above;
  logic            found;

  // Scan downwards so the last hit is the lowest qualifying index.
  always_comb begin
    above     = '0;
    found     = 1'b0;
    lowest_ch = '0;
    for (int i = 31; i >= 0; i--) begin
      if (mask[i]) begin
        lowest_ch = CH_W'(i);
        if (CH_W'(i) > ch) begin
          above = CH_W'(i);
          found = 1'b1;
        end
      end
    end
    wrapped = !found;
    next_ch = found ? above : lowest_ch;
  end

endmodule

// File: rtl/adc_readout_seq.sv
// ADC readout sequencer: enables readout, reads each enabled channel over the
// control bus and streams samples out. Optional macro ADC_SEQ_TIMEOUT_EN.
module adc_readout_seq
  import adc_seq_pkg::*;
#(
  parameter int N_ADDR         = 32,
  parameter int TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        stop,
  input  logic [31:0] chan_mask,
  output logic        running,
  adc_readout_seq_if.master bus,
  output logic [15:0] frame_count,
  output logic        marker_err,
  output logic        timeout_err
);

  localparam logic [31:0] ADDR_MASK =
    (N_ADDR >= 32) ? 32'hFFFF_FFFF : ((32'd1 << N_ADDR) - 32'd1);

  state_t          state;
  logic [31:0]     mask_q;
  logic [CH_W-1:0] ch;
  logic            first;
  logic            stop_pending;

  logic [31:0]     start_mask;
  logic [CH_W-1:0] next_ch;
  logic [CH_W-1:0] lowest_ch;
  logic            wrapped;

  assign start_mask = chan_mask & ADDR_MASK;

  adc_chan_pick u_pick (
    .mask      (mask_q),
    .ch        (ch),
    .next_ch   (next_ch),
    .wrapped   (wrapped),
    .lowest_ch (lowest_ch)
  );

  // Strobes are registered: the slave folds them into busy, so RD_WAIT's
  // first cycle always sees busy high and cannot sample stale read data.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      running        <= 1'b0;
      stop_pending   <= 1'b0;
      bus.write_req  <= 1'b0;
      bus.read_req   <= 1'b0;
      bus.addr       <= '0;
      bus.data_write <= '0;
      bus.out_valid  <= 1'b0;
      bus.out_data   <= '0;
      frame_count    <= '0;
      marker_err     <= 1'b0;
    end else begin
      bus.write_req  <= 1'b0;
      bus.read_req   <= 1'b0;
      bus.addr       <= '0;
      bus.data_write <= '0;

      if (stop && state != IDLE) stop_pending <= 1'b1;

      unique case (state)
        IDLE: begin
          if (start && start_mask != '0) begin
            mask_q  <= start_mask;
            running <= 1'b1;
            state   <= EN_WR;
          end
        end

        EN_WR: begin
          if (!bus.busy) begin
            bus.write_req  <= 1'b1;
            bus.addr       <= ADDR_ENABLE;
            bus.data_write <= 32'd1;
            ch             <= lowest_ch;
            first          <= 1'b1;
            state          <= SCAN;
          end
        end

        // Channel boundary: the only place a pending stop takes effect.
        SCAN: state <= (stop_pending || stop) ? DIS_WR : RD_REQ;

        RD_REQ: begin
          if (!bus.busy) begin
            bus.read_req <= 1'b1;
            bus.addr     <= {{(ADDR_W-CH_W){1'b0}}, ch};
            state        <= RD_WAIT;
          end
        end

        RD_WAIT: begin
          if (!bus.busy) begin
            if (bus.data_read[BUS_W-1:SAMPLE_W] != VALID_MARKER) marker_err <= 1'b1;
            bus.out_data  <= pack_sample(first, ch, bus.data_read[SAMPLE_W-1:0]);
            bus.out_valid <= 1'b1;
            state         <= PUSH;
          end
        end

        PUSH: begin
          if (bus.out_ready) begin
            bus.out_valid <= 1'b0;
            first         <= wrapped;
            ch            <= next_ch;
            if (wrapped) frame_count <= frame_count + 16'd1;
            state         <= SCAN;
          end
        end

        DIS_WR: begin
          if (!bus.busy) begin
            bus.write_req  <= 1'b1;
            bus.addr       <= ADDR_ENABLE;
            bus.data_write <= '0;
            running        <= 1'b0;
            stop_pending   <= 1'b0;
            state          <= IDLE;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

`ifdef ADC_SEQ_TIMEOUT_EN
  logic [15:0] wait_cnt;

  // The slave cannot abort a read, so a timeout only flags; the FSM waits on.
  always_ff @(posedge clk) begin
    if (reset) begin
      timeout_err <= 1'b0;
      wait_cnt    <= '0;
    end else if (state == RD_REQ) begin
      wait_cnt <= '0;
    end else if (state == RD_WAIT && bus.busy) begin
      if (wait_cnt == 16'(TIMEOUT_CYCLES - 1)) timeout_err <= 1'b1;
      if (wait_cnt != 16'hFFFF) wait_cnt <= wait_cnt + 16'd1;
    end
  end
`else
  // TIMEOUT_CYCLES only matters in the timeout build.
  assign timeout_err = 1'b0 && (TIMEOUT_CYCLES != 0);
`endif

endmodule
